// File: rtl/spike_dispatcher.sv
// Spike dispatcher: turns weight-load requests and queued spike events into
// one-cycle strobes for a downstream accumulator, and closes each time step
// with a single time_step pulse once the spikes that arrived before the step
// request have been dispatched.
// Optional feature macro: DISPATCH_STATS_EN adds a 16-bit spike_count output
// holding the number of events dispatched in the previous time step.
module spike_dispatcher #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned WEIGHT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    output logic                cfg_ready,
    input  logic                spike_valid,
    input  logic [ADDR_W-1:0]   spike_addr,
    output logic                spike_ready,
    input  logic                step_req,
    output logic                load,
    output logic [ADDR_W-1:0]   src_addr,
    output logic [WEIGHT_W-1:0] weight_in,
    output logic                time_step,
    output logic                busy
`ifdef DISPATCH_STATS_EN
    ,
    output logic [15:0]         spike_count
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StLoad     = 3'd1;
    localparam logic [2:0] StLoadGap  = 3'd2;
    localparam logic [2:0] StDispatch = 3'd3;
    localparam logic [2:0] StStep     = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    // Entries still to dispatch before the pending time_step pulse
    logic [CNT_W-1:0]    drain_q, drain_d;
    logic                pending_q, pending_d;

    logic                load_q, load_d;
    logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
    logic [WEIGHT_W-1:0] weight_in_q, weight_in_d;
    logic                time_step_q, time_step_d;

    logic fifo_empty, fifo_full;
    logic push, pop, cfg_hs, step_accept;

    // Handshake qualifiers; address 0 is handshaken but never queued
    always_comb begin
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
        spike_ready = !fifo_full;
        cfg_ready   = (state_q == StIdle) && fifo_empty && !pending_q;
        cfg_hs      = cfg_valid && cfg_ready;
        push        = spike_valid && !fifo_full && (spike_addr != '0);
        step_accept = step_req && !pending_q;
        busy        = (state_q != StIdle) || !fifo_empty;
    end

    // Next-state and pop decision
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (cfg_hs) begin
                    state_d = StLoad;
                end else if (pending_q && (drain_q == '0)) begin
                    state_d = StStep;
                end else if (!fifo_empty) begin
                    state_d = StDispatch;
                end
            end
            StLoad:    state_d = StLoadGap;
            StLoadGap: state_d = StIdle;
            StDispatch: begin
                if (pending_q) begin
                    // Only entries older than the step request go out first
                    if (drain_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StStep;
                    end
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StStep:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Occupancy, step-pending flag and snapshot counter
    always_comb begin
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        pending_d = pending_q;
        drain_d   = drain_q;
        if (step_accept) begin
            pending_d = 1'b1;
            drain_d   = count_q - CNT_W'(pop);
        end else if (pending_q && pop) begin
            drain_d = drain_q - CNT_W'(1);
        end
        if (state_q == StStep) begin
            pending_d = 1'b0;
            drain_d   = '0;
        end
    end

    // Registered accumulator-side outputs
    always_comb begin
        load_d      = 1'b0;
        src_addr_d  = '0;
        weight_in_d = '0;
        time_step_d = (state_d == StStep);
        if (cfg_hs) begin
            load_d      = 1'b1;
            src_addr_d  = cfg_addr;
            weight_in_d = cfg_weight;
        end else if (pop) begin
            src_addr_d = mem_q[rd_ptr_q];
        end
    end

    // Queue storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= spike_addr;
        end
    end

    // Control state, pointers and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drain_q     <= '0;
            pending_q   <= 1'b0;
            load_q      <= 1'b0;
            src_addr_q  <= '0;
            weight_in_q <= '0;
            time_step_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            drain_q     <= drain_d;
            pending_q   <= pending_d;
            load_q      <= load_d;
            src_addr_q  <= src_addr_d;
            weight_in_q <= weight_in_d;
            time_step_q <= time_step_d;
            // Power-of-two depth lets the pointers wrap naturally
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign load      = load_q;
    assign src_addr  = src_addr_q;
    assign weight_in = weight_in_q;
    assign time_step = time_step_q;

`ifdef DISPATCH_STATS_EN
    logic [15:0] evt_cnt_q;
    logic [15:0] spike_count_q;

    // Count dispatched events per time step; publish and restart on step entry
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt_q     <= '0;
            spike_count_q <= '0;
        end else if (time_step_d) begin
            spike_count_q <= evt_cnt_q;
            evt_cnt_q     <= '0;
        end else if (pop && (evt_cnt_q != 16'hFFFF)) begin
            evt_cnt_q <= evt_cnt_q + 16'd1;
        end
    end

    assign spike_count = spike_count_q;
`endif

endmodule

// File: doc/spike_dispatcher.md
SPIKE_DISPATCHER -- requirements
Module: spike_dispatcher

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8 (power of two, >=2), spike queue entries.
REQ-002 SHALL have parameter ADDR_W, default 10, source-address width.
REQ-003 SHALL have parameter WEIGHT_W, default 32, weight width.
REQ-004 Ports SHALL be:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  weight-load request.
- cfg_addr  in  ADDR_W  source address to program.
- cfg_weight  in  WEIGHT_W  weight to program.
- cfg_ready  out  1  weight-load request accepted this cycle when high with cfg_valid.
- spike_valid  in  1  incoming spike event.
- spike_addr  in  ADDR_W  source neuron of the spike.
- spike_ready  out  1  spike accepted when high with spike_valid.
- step_req  in  1  end-of-time-step request pulse.
- load  out  1  accumulator weight-write strobe.
- src_addr  out  ADDR_W  accumulator source address; 0 = no event.
- weight_in  out  WEIGHT_W  accumulator weight data.
- time_step  out  1  accumulator time-step pulse.
- busy  out  1  high whenever state is not IDLE or the FIFO is non-empty.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, LOAD_GAP, DISPATCH, STEP.
REQ-006 cfg_ready SHALL equal (state==IDLE && FIFO empty && no step pending).
REQ-007 On cfg handshake: next cycle LOAD, with load=1, src_addr=cfg_addr, weight_in=cfg_weight for exactly one cycle; then LOAD_GAP (load=0, src_addr=0, weight_in=0) for one cycle; then IDLE.
REQ-008 spike_ready SHALL equal !FIFO_full; spikes SHALL be accepted in every state, including LOAD, LOAD_GAP and STEP.
REQ-009 A spike with spike_addr==0 SHALL be handshaken but discarded (not queued).
REQ-010 IDLE -> DISPATCH when FIFO non-empty and cfg handshake not occurring; cfg handshake takes priority only when FIFO empty (per REQ-006).
REQ-011 In DISPATCH SHALL pop one entry per cycle and drive it on src_addr for exactly one cycle (registered, 1-cycle latency from pop); load=0, weight_in=0.
REQ-012 Duplicate consecutive addresses SHALL be dispatched as separate one-cycle events.
REQ-013 DISPATCH -> IDLE when FIFO becomes empty and no step pending; src_addr SHALL return to 0 in the cycle after the last event.
REQ-014 A step_req pulse SHALL set a step-pending flag; further step_req while pending SHALL be ignored.
REQ-015 With step pending, SHALL drain only entries queued before step_req arrived (snapshot count), then enter STEP: time_step=1 for exactly one cycle, src_addr=0, then clear pending and return to IDLE.
REQ-016 Spikes pushed after step_req SHALL remain queued and dispatch only after the time_step pulse.
REQ-017 Simultaneous push and pop when full SHALL not occur (spike_ready low when full); simultaneous push and pop otherwise SHALL keep occupancy unchanged.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH without loss or reordering.

Reset
REQ-019 On rst: state=IDLE, FIFO empty, pending cleared, load=0, src_addr=0, weight_in=0, time_step=0, busy=0, cfg_ready=1, spike_ready=1.
REQ-020 rst mid-LOAD or mid-DISPATCH SHALL abort immediately; queued spikes SHALL be discarded.

Configuration
REQ-021 With DISPATCH_STATS_EN defined SHALL add output spike_count [15:0]: counts events driven on src_addr since last time_step, saturating at 16'hFFFF, captured to output at the time_step cycle and cleared in the internal counter; reset 0.
REQ-022 Without DISPATCH_STATS_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-023 Reset, then cfg 0x001/0x00000001 -> load=1, src_addr=0x001, weight_in=1 for one cycle, then one cycle all zero, cfg_ready high again 3 cycles after handshake.
REQ-024 Push 1,2,3,2 back-to-back -> src_addr shows 1,2,3,2 on four consecutive cycles, then 0; busy drops the cycle after.
REQ-025 Push 1,2 then step_req, then push 3 -> src_addr 1,2, next cycle time_step=1, then src_addr=3.
REQ-026 Push 9 spikes with FIFO_DEPTH=8 while cfg load in progress -> spike_ready low on 9th until a pop; all 9 dispatched in order.
REQ-027 Push spike_addr 0 and 5 -> only 5 appears on src_addr; with DISPATCH_STATS_EN spike_count=1 after step.
REQ-028 Assert rst during DISPATCH with 4 queued -> next cycle src_addr=0, busy=0, no further events.
